match_stream_tx: RTL and testbench

- Consumer and transmitter for the matcher's result stream.
- Captures every single-cycle match_valid_in / match_addr_in pulse into an on-chip FIFO.
- On a match-pass-done pulse, serialises the buffered match pairs as a framed byte stream over a valid/ready link toward the host interface (UART or DMA bridge).
- Sits directly downstream of the SSD matcher.

---
 rtl/match_stream_tx.sv | 174 +++++++++++++++++
 tb/tb_match_stream_tx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/match_stream_tx.sv
// match_stream_tx: buffers matcher results and ships them
// to the host as framed bytes over a valid/ready link.
module match_stream_tx #(
  parameter int CNT_DW = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                match_valid_in,
  input  logic [2*CNT_DW-1:0] match_addr_in,
  input  logic                match_done,
  input  logic                tx_ready,
  output logic                tx_valid,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                overflow,
  output logic [AW:0]         match_count
);
  localparam int W   = 2*CNT_DW;
  localparam int BPE = W/8;
  localparam int BW  = (BPE > 1) ? $clog2(BPE) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_CNT, S_PAY, S_CHK
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   rem_q, rem_d;
  logic [BW-1:0] bidx_q, bidx_d;
  logic [7:0]    chk_q, chk_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovf_q, ovf_d;
  logic          pend_q, pend_d;

  logic          full, wr, drop, xfer, pop, start;
  logic [W-1:0]  cur_e, nxt_e;
  logic [7:0]    nb;

  function automatic logic [7:0] byte_of(
    input logic [W-1:0]  e,
    input logic [BW-1:0] k
  );
    logic [W-1:0] s;
    s = e << (8*k);
    return s[W-1 -: 8];
  endfunction

  always_comb begin
    full    = (cnt_q == (AW+1)'(DEPTH));
    wr      = match_valid_in & ~full;
    drop    = match_valid_in & full;
    xfer    = valid_q & tx_ready;
    cur_e   = mem_q[rptr_q];
    nxt_e   = mem_q[rptr_q + AW'(1)];
    pop     = (state_q == S_PAY) & xfer &
              (bidx_q == BW'(BPE-1));
    start   = 1'b0;
    nb      = '0;
    state_d = state_q;
    wptr_d  = wptr_q + AW'(wr);
    rptr_d  = rptr_q;
    cnt_d   = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    rem_d   = rem_q;
    bidx_d  = bidx_q;
    chk_d   = chk_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q | drop;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: start = match_done | pend_q;
      S_HDR: if (xfer) begin
        state_d = S_CNT;
        data_d  = 8'(rem_q);
        chk_d   = 8'(rem_q);
      end
      S_CNT: if (xfer) begin
        if (rem_q == '0) begin
          state_d = S_CHK;
          data_d  = chk_q;
        end else begin
          state_d = S_PAY;
          bidx_d  = '0;
          nb      = byte_of(cur_e, BW'(0));
          data_d  = nb;
          chk_d   = chk_q ^ nb;
        end
      end
      S_PAY: if (xfer) begin
        if (!pop) begin
          bidx_d = bidx_q + BW'(1);
          nb     = byte_of(cur_e, bidx_q + BW'(1));
          data_d = nb;
          chk_d  = chk_q ^ nb;
        end else begin
          rptr_d = rptr_q + AW'(1);
          rem_d  = rem_q - (AW+1)'(1);
          if (rem_q == (AW+1)'(1)) begin
            state_d = S_CHK;
            data_d  = chk_q;
          end else begin
            bidx_d = '0;
            nb     = byte_of(nxt_e, BW'(0));
            data_d = nb;
            chk_d  = chk_q ^ nb;
          end
        end
      end
      S_CHK: if (xfer) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        start   = pend_q;
      end
      default: state_d = S_IDLE;
    endcase
    if (match_done & (state_q != S_IDLE) & ~start)
      pend_d = 1'b1;
    // frame start: a drop in this very cycle keeps overflow set
    if (start) begin
      state_d = S_HDR;
      valid_d = 1'b1;
      data_d  = ovf_q ? 8'hA6 : 8'hA5;
      rem_d   = cnt_q;
      chk_d   = '0;
      ovf_d   = drop;
      pend_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= match_addr_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      bidx_q  <= '0;
      chk_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      bidx_q  <= bidx_d;
      chk_q   <= chk_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  assign tx_valid    = valid_q;
  assign tx_data     = data_q;
  assign busy        = (state_q != S_IDLE);
  assign overflow    = ovf_q;
  assign match_count = cnt_q;

endmodule

// File: tb/tb_match_stream_tx.sv
// tb_match_stream_tx: scoreboard bench for the match
// result framer.
module tb_match_stream_tx;
  localparam int CNT_DW = 16;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;
  localparam int W      = 2*CNT_DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          match_valid_in = 1'b0;
  logic [W-1:0]  match_addr_in = '0;
  logic          match_done = 1'b0;
  logic          tx_ready = 1'b0;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          busy;
  logic          overflow;
  logic [AW:0]   match_count;

  int n_chk  = 0;
  int n_pass = 0;
  int gaps   = 0;

  logic [7:0] exp_q [$];
  logic [W-1:0] mdl_q [$];
  logic mdl_ovf = 1'b0;

  match_stream_tx #(
    .CNT_DW(CNT_DW), .DEPTH(DEPTH), .AW(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .match_valid_in(match_valid_in),
    .match_addr_in(match_addr_in),
    .match_done(match_done),
    .tx_ready(tx_ready),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .busy(busy),
    .overflow(overflow),
    .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    if (tx_valid) begin
      check("tx_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        if (tx_ready) begin
          check("tx_byte", 32'(tx_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end else begin
          check("tx_hold", 32'(tx_data), 32'(exp_q[0]));
        end
      end
    end else if (tx_ready && exp_q.size() != 0) begin
      gaps++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [W-1:0] v);
    match_valid_in = 1'b1;
    match_addr_in  = v;
    if (mdl_q.size() < DEPTH) mdl_q.push_back(v);
    else mdl_ovf = 1'b1;
    tick();
    match_valid_in = 1'b0;
  endtask

  task automatic push_frame();
    logic [7:0] c, b;
    logic [W-1:0] e;
    c = 8'(mdl_q.size());
    exp_q.push_back(mdl_ovf ? 8'hA6 : 8'hA5);
    exp_q.push_back(c);
    foreach (mdl_q[i]) begin
      e = mdl_q[i];
      for (int k = 0; k < W/8; k++) begin
        b = e[W-1-8*k -: 8];
        exp_q.push_back(b);
        c = c ^ b;
      end
    end
    exp_q.push_back(c);
    mdl_q.delete();
    mdl_ovf = 1'b0;
  endtask

  task automatic push_bytes(input logic [7:0] b []);
    foreach (b[i]) exp_q.push_back(b[i]);
  endtask

  task automatic done();
    match_done = 1'b1;
    tick();
    match_done = 1'b0;
  endtask

  task automatic drain(input bit rnd);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      t++;
    end
    check("drain_done", 32'(t < 3000), 1);
    check("queue_left", 32'(exp_q.size()), 0);
    tx_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] single [];
    logic [7:0] empty [];
    single = '{8'hA5, 8'h01, 8'h00, 8'h12,
               8'h00, 8'h34, 8'h27};
    empty  = '{8'hA5, 8'h00, 8'h00};

    #1;
    check("rst_valid", 32'(tx_valid), 0);
    check("rst_data", 32'(tx_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_count", 32'(match_count), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tx_ready = 1'b1;
    tick();

    wr(32'h0012_0034);
    check("single_count", 32'(match_count), 1);
    mdl_q.delete();
    push_bytes(single);
    done();
    check("single_busy", 32'(busy), 1);
    drain(0);
    check("single_idle", 32'(busy), 0);
    check("single_empty", 32'(match_count), 0);

    push_bytes(empty);
    done();
    drain(0);
    check("empty_ovf", 32'(overflow), 0);
    check("empty_count", 32'(match_count), 0);

    for (int i = 0; i <= 64; i++) wr(W'(i));
    check("ovf_set", 32'(overflow), 1);
    check("ovf_count", 32'(match_count), 64);
    push_frame();
    done();
    check("ovf_clear", 32'(overflow), 0);
    drain(0);
    check("ovf_empty", 32'(match_count), 0);

    wr(32'h0012_0034);
    mdl_q.delete();
    push_bytes(single);
    done();
    drain(1);
    check("bp_empty", 32'(match_count), 0);

    wr(32'hDEAD_BEEF);
    wr(32'h0102_0304);
    push_frame();
    done();
    gaps = 0;
    tick();
    tick();
    wr(32'h1111_2222);
    wr(32'h3333_4444);
    wr(32'h5555_6666);
    check("mid_count", 32'(match_count), 5);
    push_frame();
    done();
    check("mid_busy", 32'(busy), 1);
    drain(0);
    check("mid_gaps", 32'(gaps), 0);
    check("mid_empty", 32'(match_count), 0);

    wr(32'hCAFE_0001);
    wr(32'hCAFE_0002);
    push_frame();
    done();
    repeat (4) tick();
    check("abort_busy_pre", 32'(busy), 1);
    rst = 1'b0;
    #1;
    check("abort_valid", 32'(tx_valid), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_count", 32'(match_count), 0);
    exp_q.delete();
    mdl_q.delete();
    mdl_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    push_frame();
    done();
    drain(0);
    check("abort_after", 32'(match_count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
